// File: rtl/sipo_frame_ctrl.sv
// Serial-to-parallel frame receiver: start bit, MSB-first data, optional even parity, stop bit.
// Latency: q/q_valid update on the edge that samples a good stop bit. A full holding word with rd_ready=0 drops the new word and sets overrun.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_sin,
    input  logic             rd_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh_q;
    logic             perr_q;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;
    logic             parity_err_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             busy_q;
    logic             good_stop;
    logic             bad_stop;

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE:    if (!d_sin) state_d = DATA;
                DATA: begin
                    if (cnt_q == LAST) begin
                        if (PARITY_EN) state_d = PARITY;
                        else           state_d = STOP;
                    end
                end
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    assign good_stop = en && (state_q == STOP) &&  d_sin;
    assign bad_stop  = en && (state_q == STOP) && !d_sin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            perr_q       <= 1'b0;
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            frame_err_q <= bad_stop;

            if (en) begin
                case (state_q)
                    IDLE: begin
                        if (!d_sin) begin
                            cnt_q  <= '0;
                            perr_q <= 1'b0;
                        end
                    end
                    DATA: begin
                        sh_q  <= {sh_q[WIDTH-2:0], d_sin};
                        cnt_q <= cnt_q + 1'b1;
                    end
                    PARITY:  perr_q <= PARITY_EN & ((^sh_q) ^ d_sin);
                    default: ;
                endcase
            end

            // Consume-and-load on the same edge keeps q_valid high and is not an overrun.
            if (good_stop && (!q_valid_q || rd_ready)) begin
                q_q          <= sh_q;
                parity_err_q <= PARITY_EN & perr_q;
                q_valid_q    <= 1'b1;
            end else if (q_valid_q && rd_ready) begin
                q_valid_q <= 1'b0;
            end

            if (good_stop && q_valid_q && !rd_ready) overrun_q <= 1'b1;
            else if (clr_err)                         overrun_q <= 1'b0;
        end
    end

    assign q          = q_q;
    assign q_valid    = q_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl, WIDTH=4 with even parity.
module tb_sipo_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       d_sin;
    logic       rd_ready;
    logic       clr_err;
    logic [3:0] q;
    logic       q_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .d_sin      (d_sin),
        .rd_ready   (rd_ready),
        .clr_err    (clr_err),
        .q          (q),
        .q_valid    (q_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let one rising edge pass, return at the following falling edge.
    task automatic cyc(input logic b);
        d_sin = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [6:0] bits, input logic rdy_stop, input logic clr_stop);
        for (int i = 6; i >= 1; i--) cyc(bits[i]);
        rd_ready = rdy_stop;
        clr_err  = clr_stop;
        cyc(bits[0]);
        rd_ready = 1'b0;
        clr_err  = 1'b0;
        d_sin    = 1'b1;
    endtask

    task automatic consume();
        rd_ready = 1'b1;
        cyc(1'b1);
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; d_sin = 1'b1; rd_ready = 1'b0; clr_err = 1'b0;
        #12;
        chk("reset q",          q,          4'h0);
        chk("reset q_valid",    q_valid,    1'b0);
        chk("reset parity_err", parity_err, 1'b0);
        chk("reset frame_err",  frame_err,  1'b0);
        chk("reset overrun",    overrun,    1'b0);
        chk("reset busy",       busy,       1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        chk("idle busy", busy, 1'b0);

        // Good frame: start, 1011, parity 1, stop.
        cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b1);
        chk("good pre-stop q_valid", q_valid, 1'b0);
        chk("good pre-stop busy",    busy,    1'b1);
        cyc(1'b1);
        chk("good q",          q,          4'b1011);
        chk("good q_valid",    q_valid,    1'b1);
        chk("good parity_err", parity_err, 1'b0);
        chk("good busy",       busy,       1'b0);
        consume();
        chk("consume q_valid", q_valid, 1'b0);
        chk("consume q hold",  q,       4'b1011);
        consume();
        chk("rd_ready idle q_valid", q_valid, 1'b0);

        // Parity error: odd number of ones across data+parity.
        send_frame(7'b0101101, 1'b0, 1'b0);
        chk("perr q",          q,          4'b1011);
        chk("perr q_valid",    q_valid,    1'b1);
        chk("perr parity_err", parity_err, 1'b1);
        consume();

        // Frame error: stop bit low.
        send_frame(7'b0011000, 1'b0, 1'b0);
        chk("ferr pulse",   frame_err, 1'b1);
        chk("ferr q_valid", q_valid,   1'b0);
        chk("ferr q kept",  q,         4'b1011);
        cyc(1'b1);
        chk("ferr pulse end", frame_err, 1'b0);
        chk("ferr busy",      busy,      1'b0);

        // Overrun: two good frames, no consumption.
        send_frame(7'b0011001, 1'b0, 1'b0);
        chk("ovr first q",      q,       4'b0110);
        chk("ovr first q_valid",q_valid, 1'b1);
        chk("ovr first overrun",overrun, 1'b0);
        send_frame(7'b0101111, 1'b0, 1'b0);
        chk("ovr retained q",  q,          4'b0110);
        chk("ovr retained pe", parity_err, 1'b0);
        chk("ovr set",         overrun,    1'b1);
        cyc(1'b1);
        chk("ovr sticky", overrun, 1'b1);
        clr_err = 1'b1;
        cyc(1'b1);
        clr_err = 1'b0;
        chk("ovr cleared", overrun, 1'b0);

        // Consume-and-load on the same edge.
        send_frame(7'b0111101, 1'b1, 1'b0);
        chk("swap q",       q,          4'b1111);
        chk("swap q_valid", q_valid,    1'b1);
        chk("swap pe",      parity_err, 1'b0);
        chk("swap overrun", overrun,    1'b0);

        // Overrun event and clr_err on the same edge: event wins.
        send_frame(7'b0000111, 1'b0, 1'b1);
        chk("ovr vs clr overrun", overrun, 1'b1);
        chk("ovr vs clr q",       q,       4'b1111);
        clr_err = 1'b1;
        cyc(1'b1);
        clr_err = 1'b0;
        chk("ovr vs clr cleared", overrun, 1'b0);
        consume();

        // Strobe gating: en alternates, line carries junk on disabled cycles.
        begin
            logic [6:0] g;
            g = 7'b0110001;
            for (int i = 6; i >= 0; i--) begin
                en = 1'b1; cyc(g[i]);
                en = 1'b0; cyc(~g[i]);
                if (i == 3) chk("gated busy hold", busy, 1'b1);
            end
            en = 1'b1;
        end
        chk("gated q",       q,          4'b1100);
        chk("gated q_valid", q_valid,    1'b1);
        chk("gated pe",      parity_err, 1'b0);
        consume();

        // Reset mid-frame after two data bits.
        cyc(1'b0); cyc(1'b1); cyc(1'b0);
        chk("mid busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid rst q",       q,         4'h0);
        chk("mid rst q_valid", q_valid,   1'b0);
        chk("mid rst busy",    busy,      1'b0);
        chk("mid rst overrun", overrun,   1'b0);
        chk("mid rst pe",      parity_err,1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1);
        chk("post rst q_valid", q_valid, 1'b0);
        send_frame(7'b0011001, 1'b0, 1'b0);
        chk("post rst q",       q,          4'b0110);
        chk("post rst q_valid", q_valid,    1'b1);
        chk("post rst pe",      parity_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
